// File: rtl/main_memory_responder_pkg.sv
// Shared definitions for the main-memory responder: default geometry, block data type and FSM states.
package main_memory_responder_pkg;

  localparam int DEFAULT_BLOCK_SIZE    = 32;
  localparam int DEFAULT_ADDRESS_WIDTH = 32;
  localparam int DEFAULT_MEM_BLOCKS    = 256;
  localparam int DEFAULT_LATENCY       = 4;
  localparam int DEFAULT_COUNTER_WIDTH = 8;

  localparam int DEFAULT_OFFSET_WIDTH = $clog2(DEFAULT_BLOCK_SIZE);
  localparam int DEFAULT_INDEX_WIDTH  = $clog2(DEFAULT_MEM_BLOCKS);

  typedef logic [8*DEFAULT_BLOCK_SIZE-1:0] blockData_t;

  typedef enum logic [1:0] {
    IDLE,
    WB_WAIT,
    FETCH_WAIT,
    RESPOND
  } memState_t;

endpackage

// File: rtl/main_memory_responder_array.sv
// Single-port block RAM: synchronous write, registered read; only the read register is reset.
module main_memory_array #(
  parameter int DATA_WIDTH = 256,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  writeEnable,
  input  logic                  readEnable,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] writeData,
  output logic [DATA_WIDTH-1:0] readData
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage kept free of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (writeEnable) begin
      mem[address] <= writeData;
    end
  end

  // The read register doubles as the held fetch result, so it only loads on a fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      readData <= '0;
    end else if (readEnable) begin
      readData <= mem[address];
    end
  end

endmodule

// File: rtl/main_memory_responder.sv
// Fixed-latency main-memory responder for cache block fetches and write-backs.
// Define MAIN_MEMORY_STATS_EN to add saturating fetchCount/writeBackCount outputs.
module main_memory_responder
  import main_memory_responder_pkg::*;
#(
  parameter int BLOCK_SIZE    = DEFAULT_BLOCK_SIZE,
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter int MEM_BLOCKS    = DEFAULT_MEM_BLOCKS,
  parameter int LATENCY       = DEFAULT_LATENCY,
  parameter int COUNTER_WIDTH = DEFAULT_COUNTER_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fetchReq,
  input  logic [ADDRESS_WIDTH-1:0] fetchAddress,
  output logic [8*BLOCK_SIZE-1:0]  fetchedData,
  output logic                     fetchValid,
  input  logic                     writeBackReq,
  input  logic [ADDRESS_WIDTH-1:0] writeBackAddress,
  input  logic [8*BLOCK_SIZE-1:0]  writeBackData,
  output logic                     writeBackAck,
  output logic                     busy
`ifdef MAIN_MEMORY_STATS_EN
  ,
  output logic [31:0]              fetchCount,
  output logic [31:0]              writeBackCount
`endif
);

  localparam int OFFSET_WIDTH = $clog2(BLOCK_SIZE);
  localparam int INDEX_WIDTH  = $clog2(MEM_BLOCKS);
  localparam int DATA_WIDTH   = 8 * BLOCK_SIZE;

  memState_t              stateReg;
  logic [COUNTER_WIDTH-1:0] counterReg;
  logic [INDEX_WIDTH-1:0] indexReg;
  logic [DATA_WIDTH-1:0]  wbDataReg;
  logic                   fetchValidReg;
  logic                   writeBackAckReg;
  logic                   busyReg;
  logic                   commitWrite;
  logic                   commitRead;

  // Offset and upper address bits are deliberately ignored: blocks alias modulo MEM_BLOCKS.
  logic unusedAddressBits;
  assign unusedAddressBits = ^{fetchAddress, writeBackAddress};

  // Memory is touched only on the edge that leaves a wait state.
  assign commitWrite = (stateReg == WB_WAIT)    && (counterReg == '0);
  assign commitRead  = (stateReg == FETCH_WAIT) && (counterReg == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg        <= IDLE;
      counterReg      <= '0;
      indexReg        <= '0;
      wbDataReg       <= '0;
      fetchValidReg   <= 1'b0;
      writeBackAckReg <= 1'b0;
      busyReg         <= 1'b0;
    end else begin
      case (stateReg)
        IDLE: begin
          fetchValidReg   <= 1'b0;
          writeBackAckReg <= 1'b0;
          // Write-back has priority so a following fetch of the same block sees the new data.
          if (writeBackReq) begin
            indexReg   <= writeBackAddress[OFFSET_WIDTH +: INDEX_WIDTH];
            wbDataReg  <= writeBackData;
            counterReg <= COUNTER_WIDTH'(LATENCY - 1);
            busyReg    <= 1'b1;
            stateReg   <= WB_WAIT;
          end else if (fetchReq) begin
            indexReg   <= fetchAddress[OFFSET_WIDTH +: INDEX_WIDTH];
            counterReg <= COUNTER_WIDTH'(LATENCY - 1);
            busyReg    <= 1'b1;
            stateReg   <= FETCH_WAIT;
          end
        end
        WB_WAIT: begin
          if (counterReg == '0) begin
            writeBackAckReg <= 1'b1;
            stateReg        <= RESPOND;
          end else begin
            counterReg <= counterReg - 1'b1;
          end
        end
        FETCH_WAIT: begin
          if (counterReg == '0) begin
            fetchValidReg <= 1'b1;
            stateReg      <= RESPOND;
          end else begin
            counterReg <= counterReg - 1'b1;
          end
        end
        RESPOND: begin
          fetchValidReg   <= 1'b0;
          writeBackAckReg <= 1'b0;
          busyReg         <= 1'b0;
          stateReg        <= IDLE;
        end
        default: begin
          fetchValidReg   <= 1'b0;
          writeBackAckReg <= 1'b0;
          busyReg         <= 1'b0;
          stateReg        <= IDLE;
        end
      endcase
    end
  end

  assign fetchValid   = fetchValidReg;
  assign writeBackAck = writeBackAckReg;
  assign busy         = busyReg;

  main_memory_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (MEM_BLOCKS),
    .ADDR_WIDTH(INDEX_WIDTH)
  ) memArray (
    .clk        (clk),
    .rst        (rst),
    .writeEnable(commitWrite),
    .readEnable (commitRead),
    .address    (indexReg),
    .writeData  (wbDataReg),
    .readData   (fetchedData)
  );

`ifdef MAIN_MEMORY_STATS_EN
  // Index 0 counts fetch responses, index 1 counts committed write-backs.
  logic [1:0] statEvent;
  assign statEvent = {commitWrite, commitRead};

  for (genvar gi = 0; gi < 2; gi++) begin : statGen
    logic [31:0] countReg;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        countReg <= '0;
      end else if (statEvent[gi] && (countReg != '1)) begin
        countReg <= countReg + 1'b1;
      end
    end
  end

  assign fetchCount     = statGen[0].countReg;
  assign writeBackCount = statGen[1].countReg;
`endif

endmodule
